// File: rtl/dfu_skew_fetch.sv
// dfu_skew_fetch: pops one compute instruction and sweeps skewed per-lane A/B SRAM reads
// Ports: clk, rst (async active-low); idu2dfu_compute_fifo_empty/_instr/_instr_vld in,
//   dfu2idu_compute_instr_req out; dfu2ip_{a,b}_sram_rd_en/_rd_addr per-lane reads;
//   dfu2mux_rd_en (any A lane on), dfu_busy (not IDLE), dfu_done (1-cycle end pulse).
// Define DFU_STALL_EN to add input ip2dfu_stall, which freezes the sweep while high.
module dfu_skew_fetch #(
    parameter int ROW         = 4,
    parameter int COL         = 4,
    parameter int SRAM_ADDR_W = 10,
    parameter int K_W         = 11,
    parameter int INSTR_W     = 2*SRAM_ADDR_W+K_W
) (
    input  logic                       clk,
    input  logic                       rst,
`ifdef DFU_STALL_EN
    input  logic                       ip2dfu_stall,
`endif
    input  logic                       idu2dfu_compute_fifo_empty,
    output logic                       dfu2idu_compute_instr_req,
    input  logic [INSTR_W-1:0]         idu2dfu_compute_instr,
    input  logic                       idu2dfu_compute_instr_vld,
    output logic [ROW-1:0]             dfu2ip_a_sram_rd_en,
    output logic [ROW*SRAM_ADDR_W-1:0] dfu2ip_a_sram_rd_addr,
    output logic [COL-1:0]             dfu2ip_b_sram_rd_en,
    output logic [COL*SRAM_ADDR_W-1:0] dfu2ip_b_sram_rd_addr,
    output logic                       dfu2mux_rd_en,
    output logic                       dfu_busy,
    output logic                       dfu_done
);
    localparam int MAXL = ROW > COL ? ROW : COL;
    localparam int T_W  = K_W + 2;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_SWEEP = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]                 state_q, state_d;
    logic [T_W-1:0]             t_q, t_d, t_last;
    logic [SRAM_ADDR_W-1:0]     sa_q, sa_d, sb_q, sb_d;
    logic [K_W-1:0]             k_q, k_d;
    logic                       req_q, req_d, mux_q, busy_q, done_q;
    logic [ROW-1:0]             a_en_q, a_en_d;
    logic [ROW*SRAM_ADDR_W-1:0] a_addr_q, a_addr_d;
    logic [COL-1:0]             b_en_q, b_en_d;
    logic [COL*SRAM_ADDR_W-1:0] b_addr_q, b_addr_d;
    logic                       stall;

`ifdef DFU_STALL_EN
    assign stall = ip2dfu_stall;
`else
    assign stall = 1'b0;
`endif

    // Last step at which the slowest lane still has a read to issue.
    assign t_last = T_W'(k_q) + T_W'(MAXL - 2);

    always_comb begin
        state_d  = state_q;
        t_d      = t_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        k_d      = k_q;
        req_d    = req_q;
        a_en_d   = '0;
        a_addr_d = '0;
        b_en_d   = '0;
        b_addr_d = '0;
        case (state_q)
            S_IDLE:  state_d = idu2dfu_compute_fifo_empty ? S_IDLE : S_REQ;
            S_REQ: begin
                req_d   = 1'b1;
                state_d = S_FETCH;
            end
            S_FETCH: if (idu2dfu_compute_instr_vld) begin
                req_d   = 1'b0;
                sa_d    = idu2dfu_compute_instr[SRAM_ADDR_W-1:0];
                sb_d    = idu2dfu_compute_instr[2*SRAM_ADDR_W-1:SRAM_ADDR_W];
                k_d     = idu2dfu_compute_instr[INSTR_W-1:2*SRAM_ADDR_W];
                t_d     = '0;
                state_d = idu2dfu_compute_instr[INSTR_W-1:2*SRAM_ADDR_W] == '0 ? S_DONE : S_SWEEP;
            end
            S_SWEEP: if (stall) begin
                // Frozen step: re-register the current outputs unchanged.
                a_en_d   = a_en_q;
                a_addr_d = a_addr_q;
                b_en_d   = b_en_q;
                b_addr_d = b_addr_q;
            end else begin
                // Lane i lags lane 0 by i steps and reads k_len consecutive words.
                for (int i = 0; i < ROW; i++) begin
                    a_en_d[i] = t_q >= T_W'(i) && t_q < T_W'(k_q) + T_W'(i);
                    a_addr_d[i*SRAM_ADDR_W +: SRAM_ADDR_W] = a_en_d[i] ? sa_q + SRAM_ADDR_W'(t_q - T_W'(i)) : '0;
                end
                for (int j = 0; j < COL; j++) begin
                    b_en_d[j] = t_q >= T_W'(j) && t_q < T_W'(k_q) + T_W'(j);
                    b_addr_d[j*SRAM_ADDR_W +: SRAM_ADDR_W] = b_en_d[j] ? sb_q + SRAM_ADDR_W'(t_q - T_W'(j)) : '0;
                end
                t_d     = t_q + 1'b1;
                state_d = t_q == t_last ? S_DONE : S_SWEEP;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            t_q      <= '0;
            sa_q     <= '0;
            sb_q     <= '0;
            k_q      <= '0;
            req_q    <= 1'b0;
            a_en_q   <= '0;
            a_addr_q <= '0;
            b_en_q   <= '0;
            b_addr_q <= '0;
            mux_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            t_q      <= t_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            k_q      <= k_d;
            req_q    <= req_d;
            a_en_q   <= a_en_d;
            a_addr_q <= a_addr_d;
            b_en_q   <= b_en_d;
            b_addr_q <= b_addr_d;
            mux_q    <= |a_en_d;
            busy_q   <= state_d != S_IDLE;
            done_q   <= state_d == S_DONE;
        end
    end

    assign dfu2idu_compute_instr_req = req_q;
    assign dfu2ip_a_sram_rd_en       = a_en_q;
    assign dfu2ip_a_sram_rd_addr     = a_addr_q;
    assign dfu2ip_b_sram_rd_en       = b_en_q;
    assign dfu2ip_b_sram_rd_addr     = b_addr_q;
    assign dfu2mux_rd_en             = mux_q;
    assign dfu_busy                  = busy_q;
    assign dfu_done                  = done_q;
endmodule
